cpu_sequencer: RTL

Multi-cycle fetch/execute sequencer for the CSE141L core. Consumes the decoded strobes from the Control (ID) block plus the datapath zero flag. Drives PC update, IR load, gated register/overflow write enables and a ready-handshaked data-memory request. Also provides start/done control and performance counters for the host bench.

---
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer for the CSE141L core.
//
// Takes the decoded strobes from the Control (ID) block and the datapath zero flag. It drives:
//   - PC update: PCClear, PCWrite, PCSel
//   - IR load: IRWrite
//   - gated write enables: RegWriteEn, OvWriteEn
//   - a ready-handshaked data-memory request: MemReq, MemWe (completed by MemReady)
//
// For the host bench it also provides run control and performance counters:
//   - Start begins execution
//   - Busy, Done and Error report status
//   - CycleCount and InstrCount are saturating counters, cleared on an accepted Start
//
// All control outputs are combinational from the current state and the decoded inputs.
module cpu_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             RegWrite,
  input  logic             OvWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic             BranchCond,
  input  logic             Halt,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCClear,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             IRWrite,
  output logic             RegWriteEn,
  output logic             OvWriteEn,
  output logic             MemReq,
  output logic             MemWe,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int unsigned ToW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalted, StError} state_e;

  state_e           state_q, state_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             start_acc;
  logic             instr_inc;

  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    start_acc  = 1'b0;
    instr_inc  = 1'b0;
    PCClear    = 1'b0;
    PCWrite    = 1'b0;
    PCSel      = 1'b0;
    IRWrite    = 1'b0;
    RegWriteEn = 1'b0;
    OvWriteEn  = 1'b0;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    case (state_q)
      StIdle, StHalted, StError: begin
        if (Start) begin
          PCClear   = 1'b1;
          start_acc = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        IRWrite = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        if (Halt) begin
          instr_inc = 1'b1;
          state_d   = StHalted;
        end else if (MemRead || MemWrite) begin
          to_d    = '0;
          state_d = StMem;
        end else begin
          PCWrite    = 1'b1;
          RegWriteEn = RegWrite;
          OvWriteEn  = OvWrite;
          PCSel      = Branch & (~BranchCond | Zero);
          instr_inc  = 1'b1;
          state_d    = StFetch;
        end
      end
      StMem: begin
        MemReq = 1'b1;
        MemWe  = MemWrite;
        if (MemReady) begin
          // A simultaneous read+write decode is treated as a store: no load writeback.
          RegWriteEn = MemRead & ~MemWrite;
          PCWrite    = 1'b1;
          instr_inc  = 1'b1;
          state_d    = StFetch;
        end else begin
          to_d = to_q + 1'b1;
          // to_q counts completed wait cycles, so this is the MEM_TIMEOUT-th MEM cycle.
          if (to_q == ToW'(MEM_TIMEOUT - 1)) begin
            state_d = StError;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign Busy  = (state_q == StFetch) || (state_q == StExec) || (state_q == StMem);
  assign Done  = (state_q == StHalted) || (state_q == StError);
  assign Error = (state_q == StError);

  // Saturating counters; Start is only accepted outside Busy so clear and count never collide.
  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (start_acc) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      if (Busy && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
      if (instr_inc && (ins_q != '1)) ins_d = ins_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      to_q    <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  assign CycleCount = cyc_q;
  assign InstrCount = ins_q;

endmodule
